// File: rtl/channel_plane_sequencer_if.sv
// Stream bundle for channel_plane_sequencer: interleaved-pixel input, single-channel output,
// plus the extractor offset exposed for observability.
interface channel_plane_sequencer_if #(
   parameter int TDATA_WIDTH   = 256,
   parameter int CHANNEL_COUNT = 3
);
   localparam int CHANNEL_COUNT_BITS = $clog2(CHANNEL_COUNT);

   logic [TDATA_WIDTH-1:0]        s_axis_tdata;
   logic                          s_axis_tvalid;
   logic                          s_axis_tready;
   logic                          s_axis_tlast;
   logic [TDATA_WIDTH-1:0]        m_axis_tdata;
   logic                          m_axis_tvalid;
   logic                          m_axis_tready;
   logic                          m_axis_tlast;
   logic [CHANNEL_COUNT_BITS-1:0] m_axis_tuser;
   logic [CHANNEL_COUNT_BITS-1:0] channel_offset;

   modport slave (
      input  s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
      output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
             channel_offset
   );

   modport master (
      output s_axis_tdata, s_axis_tvalid, s_axis_tlast, m_axis_tready,
      input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
             channel_offset
   );
endinterface

// File: rtl/channel_plane_sequencer.sv
// Re-emits each interleaved-pixel beat once per colour channel, tracking the rotating channel
// phase of item 0. Optional one-entry input skid register: CHANNEL_PLANE_SEQ_SKID_EN.
module channel_plane_sequencer #(
   parameter int TDATA_WIDTH   = 256,
   parameter int ITEM_WIDTH    = 8,
   parameter int CHANNEL_COUNT = 3
) (
   input  logic                     axis_aclk,
   input  logic                     axis_reset,
   channel_plane_sequencer_if.slave axis
);
   localparam int ITEM_COUNT         = TDATA_WIDTH / ITEM_WIDTH;
   localparam int CHANNEL_COUNT_BITS = $clog2(CHANNEL_COUNT);
   localparam int PHASE_STEP         = ITEM_COUNT % CHANNEL_COUNT;
   localparam logic [CHANNEL_COUNT_BITS-1:0] LAST_CH = CHANNEL_COUNT_BITS'(CHANNEL_COUNT - 1);

   typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

   state_t                        state_q, state_d;
   logic [CHANNEL_COUNT_BITS-1:0] ch_q, ch_d;
   logic [CHANNEL_COUNT_BITS-1:0] phase_q, phase_d;
   logic [TDATA_WIDTH-1:0]        hold_data_q, hold_data_d;
   logic                          hold_last_q, hold_last_d;

   logic                          s_ready, s_hs, done;
   logic                          ld_vld, ld_last;
   logic [TDATA_WIDTH-1:0]        ld_data;
   logic [CHANNEL_COUNT_BITS-1:0] offset;
   logic [TDATA_WIDTH-1:0]        extract;

   // Both operands are below CHANNEL_COUNT, so one conditional subtract replaces the modulo.
   function automatic logic [CHANNEL_COUNT_BITS-1:0] offset_of(
      input logic [CHANNEL_COUNT_BITS-1:0] c, input logic [CHANNEL_COUNT_BITS-1:0] p);
      int sum;
      sum = int'(c) + CHANNEL_COUNT - int'(p);
      if (sum >= CHANNEL_COUNT) sum = sum - CHANNEL_COUNT;
      return CHANNEL_COUNT_BITS'(sum);
   endfunction

   function automatic logic [CHANNEL_COUNT_BITS-1:0] next_phase(
      input logic [CHANNEL_COUNT_BITS-1:0] p);
      int n;
      n = int'(p) + PHASE_STEP;
      if (n >= CHANNEL_COUNT) n = n - CHANNEL_COUNT;
      return CHANNEL_COUNT_BITS'(n);
   endfunction

   assign done = (state_q == EMIT) && axis.m_axis_tready && (ch_q == LAST_CH);
   assign s_hs = axis.s_axis_tvalid && s_ready;

`ifdef CHANNEL_PLANE_SEQ_SKID_EN
   logic                   skid_vld_q, skid_vld_d;
   logic [TDATA_WIDTH-1:0] skid_data_q, skid_data_d;
   logic                   skid_last_q, skid_last_d;
   logic                   s_ready_q;
   logic                   hold_free;

   assign hold_free = (state_q == IDLE) || done;
   assign s_ready   = s_ready_q;
   // A parked beat always wins over the port; the port cannot fire while the skid is full.
   assign ld_vld    = skid_vld_q || s_hs;
   assign ld_data   = skid_vld_q ? skid_data_q : axis.s_axis_tdata;
   assign ld_last   = skid_vld_q ? skid_last_q : axis.s_axis_tlast;

   always_comb begin
      skid_vld_d  = skid_vld_q;
      skid_data_d = skid_data_q;
      skid_last_d = skid_last_q;
      if (hold_free) begin
         skid_vld_d = 1'b0;
      end else if (s_hs) begin
         skid_vld_d  = 1'b1;
         skid_data_d = axis.s_axis_tdata;
         skid_last_d = axis.s_axis_tlast;
      end
   end
`else
   assign s_ready = (state_q == IDLE) || done;
   assign ld_vld  = s_hs;
   assign ld_data = axis.s_axis_tdata;
   assign ld_last = axis.s_axis_tlast;
`endif

   always_comb begin
      state_d     = state_q;
      ch_d        = ch_q;
      phase_d     = phase_q;
      hold_data_d = hold_data_q;
      hold_last_d = hold_last_q;
      case (state_q)
         IDLE: begin
            if (ld_vld) begin
               hold_data_d = ld_data;
               hold_last_d = ld_last;
               ch_d        = '0;
               state_d     = EMIT;
            end
         end
         default: begin
            if (axis.m_axis_tready) begin
               if (ch_q != LAST_CH) begin
                  ch_d = ch_q + 1'b1;
               end else begin
                  phase_d = hold_last_q ? '0 : next_phase(phase_q);
                  if (ld_vld) begin
                     hold_data_d = ld_data;
                     hold_last_d = ld_last;
                     ch_d        = '0;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
      endcase
   end

   always_ff @(posedge axis_aclk or posedge axis_reset) begin
      if (axis_reset) begin
         state_q     <= IDLE;
         ch_q        <= '0;
         phase_q     <= '0;
         hold_data_q <= '0;
         hold_last_q <= 1'b0;
`ifdef CHANNEL_PLANE_SEQ_SKID_EN
         skid_vld_q  <= 1'b0;
         skid_data_q <= '0;
         skid_last_q <= 1'b0;
         s_ready_q   <= 1'b1;
`endif
      end else begin
         state_q     <= state_d;
         ch_q        <= ch_d;
         phase_q     <= phase_d;
         hold_data_q <= hold_data_d;
         hold_last_q <= hold_last_d;
`ifdef CHANNEL_PLANE_SEQ_SKID_EN
         skid_vld_q  <= skid_vld_d;
         skid_data_q <= skid_data_d;
         skid_last_q <= skid_last_d;
         s_ready_q   <= ~skid_vld_d;
`endif
      end
   end

   assign offset = offset_of(ch_q, phase_q);

   // Extractor: items whose index is congruent to the offset are packed from the LSB up.
   always_comb begin
      extract = '0;
      for (int i = 0; i < ITEM_COUNT; i++) begin
         if (CHANNEL_COUNT_BITS'(i % CHANNEL_COUNT) == offset)
            extract[(i / CHANNEL_COUNT) * ITEM_WIDTH +: ITEM_WIDTH] =
               hold_data_q[i * ITEM_WIDTH +: ITEM_WIDTH];
      end
   end

   assign axis.s_axis_tready  = s_ready;
   assign axis.m_axis_tvalid  = (state_q == EMIT);
   assign axis.m_axis_tdata   = extract;
   assign axis.m_axis_tuser   = ch_q;
   assign axis.m_axis_tlast   = hold_last_q && (ch_q == LAST_CH);
   assign axis.channel_offset = offset;
endmodule
